// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
//   Execute-stage controller for the 8-bit ALU. It owns a 4-entry register
//   file and runs one instruction at a time through IDLE -> EXEC -> WB. In
//   IDLE it accepts an immediate load or an instruction, with the load taking
//   priority. It presents registered operands to the ALU during EXEC and
//   writes the ALU result back at the EXEC->WB edge. A divide by zero is
//   trapped here, so the ALU's own output for that case is never stored.
//
// Ports
//   CLK, RST        clock and synchronous active-high reset
//   INSTR_VALID/INSTR/INSTR_READY
//                   instruction handshake; INSTR = {op, srcA, srcB, dest}
//   LOAD_EN/LOAD_REG/LOAD_DATA
//                   immediate register write, honoured only in IDLE
//   OPCODE, REG_A, REG_B, DATA_A, DATA_B
//                   registered ALU inputs
//   DATA_OUT        combinational ALU result
//   RESULT_VALID    one-cycle pulse while in WB
//   RESULT, RESULT_REG, DIV0
//                   last written-back value, its destination and trap flag
//   DBG_SEL/DBG_DATA
//                   combinational register file peek
// -----------------------------------------------------------------------------
module alu_ctrl #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] DIV0_VALUE = 8'hFF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INSTR_VALID,
  input  logic [7:0]       INSTR,
  output logic             INSTR_READY,
  input  logic             LOAD_EN,
  input  logic [1:0]       LOAD_REG,
  input  logic [WIDTH-1:0] LOAD_DATA,
  output logic [1:0]       OPCODE,
  output logic [1:0]       REG_A,
  output logic [1:0]       REG_B,
  output logic [WIDTH-1:0] DATA_A,
  output logic [WIDTH-1:0] DATA_B,
  input  logic [WIDTH-1:0] DATA_OUT,
  output logic             RESULT_VALID,
  output logic [WIDTH-1:0] RESULT,
  output logic [1:0]       RESULT_REG,
  output logic             DIV0,
  input  logic [1:0]       DBG_SEL,
  output logic [WIDTH-1:0] DBG_DATA
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] rf_q [4];

  logic [1:0]       opcode_q, reg_a_q, reg_b_q, dest_q, result_reg_q;
  logic [WIDTH-1:0] data_a_q, data_b_q, result_q;
  logic             div0_q;

  logic             accept;
  logic             load_write;
  logic             in_exec;
  logic             div0_cond;
  logic [WIDTH-1:0] wb_value;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    INSTR_READY  = 1'b0;
    RESULT_VALID = 1'b0;
    case (state_q)
      S_IDLE:  INSTR_READY  = !LOAD_EN;  // a load steals the IDLE cycle
      S_WB:    RESULT_VALID = 1'b1;
      default: ;
    endcase
  end

  assign accept     = INSTR_VALID && INSTR_READY;
  assign load_write = (state_q == S_IDLE) && LOAD_EN;
  assign in_exec    = (state_q == S_EXEC);

  // The trap is decided from the registered operands, never from DATA_OUT.
  assign div0_cond = (opcode_q == 2'b11) && (data_b_q == '0);
  assign wb_value  = div0_cond ? DIV0_VALUE : DATA_OUT;

  // ---------------------------------------------------------------------------
  // Register file. A load happens only in IDLE and a writeback only in EXEC,
  // so the two write sources can never collide.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else if (load_write) begin
      rf_q[LOAD_REG] <= LOAD_DATA;
    end else if (in_exec) begin
      rf_q[dest_q] <= wb_value;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture on accept, result capture at EXEC->WB
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      opcode_q     <= '0;
      reg_a_q      <= '0;
      reg_b_q      <= '0;
      dest_q       <= '0;
      data_a_q     <= '0;
      data_b_q     <= '0;
      result_q     <= '0;
      result_reg_q <= '0;
      div0_q       <= 1'b0;
    end else begin
      if (accept) begin
        opcode_q <= INSTR[7:6];
        reg_a_q  <= INSTR[5:4];
        reg_b_q  <= INSTR[3:2];
        dest_q   <= INSTR[1:0];
        data_a_q <= rf_q[INSTR[5:4]];
        data_b_q <= rf_q[INSTR[3:2]];
      end
      if (in_exec) begin
        result_q     <= wb_value;
        result_reg_q <= dest_q;
        div0_q       <= div0_cond;
      end
    end
  end

  assign OPCODE     = opcode_q;
  assign REG_A      = reg_a_q;
  assign REG_B      = reg_b_q;
  assign DATA_A     = data_a_q;
  assign DATA_B     = data_b_q;
  assign RESULT     = result_q;
  assign RESULT_REG = result_reg_q;
  assign DIV0       = div0_q;
  assign DBG_DATA   = rf_q[DBG_SEL];

endmodule
